// File: rtl/io_bus_interconnect_pkg.sv
// rtl/io_bus_interconnect_pkg.sv - shared I/O request/response types and widths for io_bus_interconnect
package io_bus_interconnect_pkg;

  // The packet types below are sized from these; instances must use matching parameters.
  localparam int DEFAULT_NUM_CORES        = 4;
  localparam int DEFAULT_THREADS_PER_CORE = 4;

  localparam int CORE_ID_WIDTH    = (DEFAULT_NUM_CORES > 1) ? $clog2(DEFAULT_NUM_CORES) : 1;
  localparam int THREAD_IDX_WIDTH = (DEFAULT_THREADS_PER_CORE > 1) ? $clog2(DEFAULT_THREADS_PER_CORE) : 1;

  typedef logic [31:0]                 scalar_t;
  typedef logic [CORE_ID_WIDTH-1:0]    core_id_t;
  typedef logic [THREAD_IDX_WIDTH-1:0] local_thread_idx_t;

  typedef struct packed {
    logic              store;
    local_thread_idx_t thread_idx;
    scalar_t           address;
    scalar_t           value;
  } ioreq_packet_t;

  typedef struct packed {
    core_id_t          core;
    local_thread_idx_t thread_idx;
    scalar_t           read_value;
  } iorsp_packet_t;

endpackage

// File: rtl/io_bus_interface.sv
// rtl/io_bus_interface.sv - shared system I/O bus signal bundle
interface io_bus_interface;
  import io_bus_interconnect_pkg::*;

  logic    write_en;
  logic    read_en;
  scalar_t address;
  scalar_t write_data;
  scalar_t read_data;

  modport master (
    output write_en,
    output read_en,
    output address,
    output write_data,
    input  read_data
  );

  modport slave (
    input  write_en,
    input  read_en,
    input  address,
    input  write_data,
    output read_data
  );

endinterface

// File: rtl/io_bus_interconnect_rr_arbiter.sv
// rtl/io_bus_interconnect_rr_arbiter.sv - one-hot request arbiter, round robin or fixed priority (IO_INTERCONNECT_FIXED_PRIORITY_EN)
module rr_arbiter #(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update_lru,
  output logic [NUM_REQUESTERS-1:0] grant_oh
);

  localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

`ifdef IO_INTERCONNECT_FIXED_PRIORITY_EN

  // Lowest index wins; stateless, so clock/reset/update are not needed.
  logic unused_inputs;
  assign unused_inputs = ^{clk, reset, update_lru};

  // Pick the first active request scanning upward from index 0.
  always_comb begin
    logic found;
    grant_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (!found && request[i]) begin
        grant_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

`else

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;
  logic             any_grant;

  // Scan from the priority pointer with wrap-around; first active request wins.
  always_comb begin
    int               idx_full;
    logic [PTR_W-1:0] idx;
    logic             found;
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx_full  = 0;
    idx       = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      idx_full = int'(ptr) + i;
      if (idx_full >= NUM_REQUESTERS) idx_full = idx_full - NUM_REQUESTERS;
      idx = PTR_W'(idx_full);
      if (!found && request[idx]) begin
        grant_oh[idx] = 1'b1;
        grant_idx     = idx;
        found         = 1'b1;
      end
    end
  end

  assign any_grant = |grant_oh;

  // After a grant, priority moves to the requester just past the winner; otherwise it holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (update_lru && any_grant) begin
      if (grant_idx == PTR_W'(NUM_REQUESTERS - 1)) ptr <= '0;
      else                                          ptr <= grant_idx + 1'b1;
    end
  end

`endif

endmodule

// File: rtl/io_bus_interconnect.sv
// rtl/io_bus_interconnect.sv - arbitrates core I/O requests onto io_bus with fixed 2-cycle response (IO_INTERCONNECT_FIXED_PRIORITY_EN selects fixed priority)
module io_bus_interconnect
  import io_bus_interconnect_pkg::*;
#(
  parameter int NUM_CORES        = DEFAULT_NUM_CORES,
  parameter int THREADS_PER_CORE = DEFAULT_THREADS_PER_CORE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] ior_request_valid,
  input  ioreq_packet_t        ior_request [NUM_CORES],
  output logic [NUM_CORES-1:0] ii_ready,
  output logic                 ii_response_valid,
  output iorsp_packet_t        ii_response,
  io_bus_interface.master      io_bus
);

  localparam int CORE_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int THREAD_W = (THREADS_PER_CORE > 1) ? $clog2(THREADS_PER_CORE) : 1;

  logic [NUM_CORES-1:0] grant_oh;
  logic                 grant_any;
  ioreq_packet_t        grant_pkt;
  logic [CORE_W-1:0]    grant_core;
  logic [THREAD_W-1:0]  grant_thread;

  logic                 p1_valid;
  core_id_t             p1_core;
  local_thread_idx_t    p1_thread;

  core_id_t             rsp_core_q;
  local_thread_idx_t    rsp_thread_q;

  rr_arbiter #(
    .NUM_REQUESTERS (NUM_CORES)
  ) u_arbiter (
    .clk        (clk),
    .reset      (reset),
    .request    (ior_request_valid),
    .update_lru (grant_any),
    .grant_oh   (grant_oh)
  );

  // A grant always completes the handshake: the arbiter only grants active requesters.
  assign ii_ready  = grant_oh;
  assign grant_any = |grant_oh;

  // Select the winning core's packet and its index.
  always_comb begin
    grant_pkt  = '0;
    grant_core = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant_oh[i]) begin
        grant_pkt  = ior_request[i];
        grant_core = CORE_W'(i);
      end
    end
    grant_thread = THREAD_W'(grant_pkt.thread_idx);
  end

  // Bus stage: strobes follow the grant each cycle; address/data/tag hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_bus.write_en   <= 1'b0;
      io_bus.read_en    <= 1'b0;
      io_bus.address    <= '0;
      io_bus.write_data <= '0;
      p1_valid          <= 1'b0;
      p1_core           <= '0;
      p1_thread         <= '0;
    end else begin
      io_bus.write_en <= grant_any & grant_pkt.store;
      io_bus.read_en  <= grant_any & ~grant_pkt.store;
      p1_valid        <= grant_any;
      if (grant_any) begin
        io_bus.address    <= grant_pkt.address;
        io_bus.write_data <= grant_pkt.value;
        p1_core           <= core_id_t'(grant_core);
        p1_thread         <= local_thread_idx_t'(grant_thread);
      end
    end
  end

  // Response stage: one response per bus transaction, loads and stores alike.
  always_ff @(posedge clk) begin
    if (reset) begin
      ii_response_valid <= 1'b0;
      rsp_core_q        <= '0;
      rsp_thread_q      <= '0;
    end else begin
      ii_response_valid <= p1_valid;
      rsp_core_q        <= p1_core;
      rsp_thread_q      <= p1_thread;
    end
  end

  // Read data is passed straight through from the bus in the response cycle.
  always_comb begin
    ii_response            = '0;
    ii_response.core       = rsp_core_q;
    ii_response.thread_idx = rsp_thread_q;
    ii_response.read_value = io_bus.read_data;
  end

endmodule

// File: tb/tb_io_bus_interconnect.sv
// tb/tb_io_bus_interconnect.sv - directed self-checking bench for io_bus_interconnect
module tb_io_bus_interconnect;
  import io_bus_interconnect_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    req_valid;
  ioreq_packet_t req [4];
  logic [3:0]    ready;
  logic          rsp_valid;
  iorsp_packet_t rsp;

  int checks   = 0;
  int failures = 0;

  io_bus_interface bus ();

  io_bus_interconnect #(
    .NUM_CORES        (4),
    .THREADS_PER_CORE (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .ior_request_valid (req_valid),
    .ior_request       (req),
    .ii_ready          (ready),
    .ii_response_valid (rsp_valid),
    .ii_response       (rsp),
    .io_bus            (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic st, input int thr, input logic [31:0] addr, input logic [31:0] val);
    req[k] = '{store: st, thread_idx: local_thread_idx_t'(thr), address: addr, value: val};
  endtask

  logic [3:0]  cont_ready [4] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
  logic [1:0]  cont_core  [4] = '{2'd0, 2'd3, 2'd0, 2'd3};
  logic [31:0] cont_addr  [4] = '{32'h1000, 32'h1030, 32'h1000, 32'h1030};
  logic [3:0]  b2b_valid  [4] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000};
  logic [3:0]  b2b_ready  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [31:0] b2b_addr   [4] = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};
`ifdef IO_INTERCONNECT_FIXED_PRIORITY_EN
  logic [3:0]  pol_ready  [3] = '{4'b0010, 4'b0010, 4'b0010};
`else
  logic [3:0]  pol_ready  [3] = '{4'b0010, 4'b0100, 4'b0010};
`endif

  initial begin
    req_valid     = 4'b0000;
    bus.read_data = 32'h0;
    for (int k = 0; k < 4; k++) set_req(k, 1'b0, 0, 32'h0, 32'h0);

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_write_en", 64'(bus.write_en), 64'd0);
    chk("rst_read_en", 64'(bus.read_en), 64'd0);
    chk("rst_address", 64'(bus.address), 64'd0);
    chk("rst_write_data", 64'(bus.write_data), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_core", 64'(rsp.core), 64'd0);
    chk("rst_rsp_thread", 64'(rsp.thread_idx), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    reset = 1'b0;

    // single load: core 2, thread 1
    @(negedge clk);
    set_req(2, 1'b0, 1, 32'h100, 32'h0);
    req_valid = 4'b0100;
    #1 chk("load_ready", 64'(ready), 64'h4);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("load_read_en", 64'(bus.read_en), 64'd1);
    chk("load_write_en", 64'(bus.write_en), 64'd0);
    chk("load_address", 64'(bus.address), 64'h100);
    chk("load_idle_ready", 64'(ready), 64'd0);
    @(negedge clk);
    bus.read_data = 32'hDEADBEEF;
    #1;
    chk("load_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("load_rsp_core", 64'(rsp.core), 64'd2);
    chk("load_rsp_thread", 64'(rsp.thread_idx), 64'd1);
    chk("load_rsp_data", 64'(rsp.read_value), 64'hDEADBEEF);
    @(negedge clk);
    bus.read_data = 32'h0;
    #1;
    chk("load_rsp_once", 64'(rsp_valid), 64'd0);
    chk("idle_read_en", 64'(bus.read_en), 64'd0);
    chk("idle_addr_hold", 64'(bus.address), 64'h100);

    // store: core 0, thread 3
    @(negedge clk);
    set_req(0, 1'b1, 3, 32'h20, 32'h12345678);
    req_valid = 4'b0001;
    #1 chk("store_ready", 64'(ready), 64'h1);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("store_write_en", 64'(bus.write_en), 64'd1);
    chk("store_read_en", 64'(bus.read_en), 64'd0);
    chk("store_address", 64'(bus.address), 64'h20);
    chk("store_write_data", 64'(bus.write_data), 64'h12345678);
    @(negedge clk);
    #1;
    chk("store_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("store_rsp_core", 64'(rsp.core), 64'd0);
    chk("store_rsp_thread", 64'(rsp.thread_idx), 64'd3);

    // return priority to core 0
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // contention: cores 0 and 3 hold requests
    set_req(0, 1'b0, 0, 32'h1000, 32'h0);
    set_req(3, 1'b0, 2, 32'h1030, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid = (i < 4) ? 4'b1001 : 4'b0000;
      #1;
      if (i < 4) chk("cont_ready", 64'(ready), 64'(cont_ready[i]));
      if (i >= 1 && i < 5) chk("cont_address", 64'(bus.address), 64'(cont_addr[i-1]));
      if (i >= 2) begin
        chk("cont_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("cont_rsp_core", 64'(rsp.core), 64'(cont_core[i-2]));
      end
    end

    // back-to-back: all four cores, each drops after its grant
    for (int k = 0; k < 4; k++) set_req(k, 1'b0, k, b2b_addr[k], 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid = (i < 4) ? b2b_valid[i] : 4'b0000;
      #1;
      if (i < 4) chk("b2b_ready", 64'(ready), 64'(b2b_ready[i]));
      if (i >= 1 && i < 5) begin
        chk("b2b_read_en", 64'(bus.read_en), 64'd1);
        chk("b2b_address", 64'(bus.address), 64'(b2b_addr[i-1]));
      end
      if (i >= 2) begin
        chk("b2b_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("b2b_rsp_core", 64'(rsp.core), 64'(i - 2));
        chk("b2b_rsp_thread", 64'(rsp.thread_idx), 64'(i - 2));
      end
    end

    // reset during the bus cycle of a load from core 1
    @(negedge clk);
    set_req(1, 1'b0, 2, 32'h300, 32'h0);
    req_valid = 4'b0010;
    #1 chk("rstmid_ready", 64'(ready), 64'h2);
    @(negedge clk);
    req_valid = 4'b0000;
    reset = 1'b1;
    #1 chk("rstmid_read_en", 64'(bus.read_en), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    bus.read_data = 32'hCAFEF00D;
    #1;
    chk("rstmid_no_rsp", 64'(rsp_valid), 64'd0);
    chk("rstmid_read_en_off", 64'(bus.read_en), 64'd0);
    @(negedge clk);
    #1 chk("rstmid_no_rsp_late", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    bus.read_data = 32'h0;
    set_req(0, 1'b0, 0, 32'h400, 32'h0);
    set_req(2, 1'b0, 0, 32'h500, 32'h0);
    req_valid = 4'b0101;
    #1 chk("rstmid_ptr_core0", 64'(ready), 64'h1);

    // cores 1 and 2 request continuously
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 4'b0110;
      #1 chk("policy_ready", 64'(ready), 64'(pol_ready[i]));
    end

    // sole requester is granted every cycle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 4'b0100;
      #1 chk("sole_ready", 64'(ready), 64'h4);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1 chk("final_ready", 64'(ready), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
